// File: rtl/seg_scan_mux.sv
// seg_scan_mux
//
// Self-scanning digit multiplexer for a multi-digit seven-segment display.
// An internal prescaler sets how long each digit stays selected. The digit
// index then steps round-robin through the digits. Every output is registered
// from the same index in the same process, so an, cnt and dot always change
// together.
//
// Parameters
//   NUM_DIGITS : number of display digits (>= 2), digit 0 least significant
//   DIGIT_W    : bits per digit value
//   SCAN_DIV   : clock cycles each digit stays selected (>= 1)
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous reset, active high
//   en         : scan enable; when low the prescaler and digit index hold
//   digits     : packed digit values, digit i at [i*DIGIT_W +: DIGIT_W]
//   dp_mask    : bit i = 1 lights the decimal point of digit i
//   blank_lz   : enables leading-zero blanking
//   sel        : current digit index (registered)
//   an         : digit enables, active low, one-cold (all ones = all off)
//   cnt        : value of the selected digit, to the segment decoder
//   dot        : decimal point, active low
//   blank      : high while the selected digit is suppressed
//   frame_tick : one-cycle pulse, aligned with the outputs returning to digit 0

module seg_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] digits,
    input  logic [NUM_DIGITS-1:0]         dp_mask,
    input  logic                          blank_lz,
    output logic [$clog2(NUM_DIGITS)-1:0] sel,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [DIGIT_W-1:0]            cnt,
    output logic                          dot,
    output logic                          blank,
    output logic                          frame_tick
);

    localparam int SEL_W = $clog2(NUM_DIGITS);
    // A 1-bit counter is kept for SCAN_DIV = 1. It simply stays at 0, which
    // is also the terminal count, so the index advances every enabled cycle.
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]      div_cnt;
    logic [DIV_W-1:0]      div_nxt;
    logic [SEL_W-1:0]      idx;
    logic [SEL_W-1:0]      idx_nxt;
    logic                  advance;
    logic                  wrap;
    logic                  wrap_q;

    logic [NUM_DIGITS-1:0] zero_from;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  all_zero;

    logic [DIGIT_W-1:0]    sel_digit;
    logic                  sel_dp;
    logic                  sel_blank;
    logic [NUM_DIGITS-1:0] an_lit;

    // ------------------------------------------------------------------
    // Prescaler and digit index
    // ------------------------------------------------------------------
    always_comb begin
        advance = en && (div_cnt == DIV_LAST);
        wrap    = advance && (idx == IDX_LAST);

        div_nxt = div_cnt;
        if (en) begin
            if (div_cnt == DIV_LAST) begin
                div_nxt = '0;
            end else begin
                div_nxt = div_cnt + DIV_W'(1);
            end
        end

        // The explicit compare against the last digit keeps idx below
        // NUM_DIGITS even when NUM_DIGITS is not a power of two.
        idx_nxt = idx;
        if (advance) begin
            if (idx == IDX_LAST) begin
                idx_nxt = '0;
            end else begin
                idx_nxt = idx + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            idx     <= '0;
            wrap_q  <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            idx     <= idx_nxt;
            // The new index reaches the outputs one edge after the advance.
            // Delaying the wrap by one stage puts frame_tick on that same edge.
            wrap_q  <= wrap;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero detection
    // zero_from[i] is set when digits NUM_DIGITS-1 down to i are all zero.
    // Digit 0 is never blanked, so a value of zero still shows as "0".
    // ------------------------------------------------------------------
    always_comb begin
        zero_from = '0;
        lz_blank  = '0;
        all_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero     = all_zero && (digits[i*DIGIT_W +: DIGIT_W] == '0);
            zero_from[i] = all_zero;
        end
        for (int i = 1; i < NUM_DIGITS; i++) begin
            lz_blank[i] = blank_lz && zero_from[i];
        end
    end

    // ------------------------------------------------------------------
    // Digit select
    // ------------------------------------------------------------------
    always_comb begin
        sel_digit = '0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        an_lit    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == SEL_W'(i)) begin
                sel_digit = digits[i*DIGIT_W +: DIGIT_W];
                sel_dp    = dp_mask[i];
                sel_blank = lz_blank[i];
                an_lit[i] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // These refresh every cycle regardless of en, so data changes still
    // appear on a frozen digit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel        <= '0;
            an         <= '1;
            cnt        <= '0;
            dot        <= 1'b1;
            blank      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            sel        <= idx;
            frame_tick <= wrap_q;
            if (sel_blank) begin
                an    <= '1;
                cnt   <= '0;
                dot   <= 1'b1;
                blank <= 1'b1;
            end else begin
                an    <= an_lit;
                cnt   <= sel_digit;
                dot   <= ~sel_dp;
                blank <= 1'b0;
            end
        end
    end

endmodule
